// File: rtl/glyph_streamer.sv
// Glyph FIFO plus row player: buffers 3x3 glyphs and streams each as three
// registered 3-bit rows followed by GAP blank rows, for the letter reader.
module glyph_streamer #(
    parameter int DEPTH = 4,
    parameter int GAP   = 1
) (
    input  logic                     clk,
    input  logic                     restart,
    input  logic                     in_valid,
    input  logic [8:0]               in_glyph,
    output logic                     in_ready,
    output logic [2:0]               bits,
    output logic                     glyph_start,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROW0,
        S_ROW1,
        S_ROW2,
        S_SEP
    } state_t;

    // FIFO storage and bookkeeping
    logic [8:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Player state and registered outputs
    state_t        r_state;
    logic [8:0]    r_glyph;
    logic [GW-1:0] r_gap;
    logic [2:0]    r_bits;
    logic          r_start;

    state_t        w_state_nxt;
    logic [8:0]    w_glyph_nxt;
    logic [GW-1:0] w_gap_nxt;
    logic [2:0]    w_bits_nxt;
    logic          w_pop;
    logic          w_push;
    logic          w_empty;
    logic [8:0]    w_head;

    assign in_ready    = (r_count != CW'(DEPTH));
    assign w_push      = in_valid && in_ready;
    assign w_empty     = (r_count == '0);
    assign w_head      = r_mem[r_rd_ptr];
    assign busy        = !w_empty || (r_state != S_IDLE);
    assign count       = r_count;
    assign bits        = r_bits;
    assign glyph_start = r_start;

    // NOTE: the glyph array carries no reset; the pointers and count alone
    // decide which entries are live, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_glyph;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge restart) begin
        if (restart) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge restart) begin
        if (restart) begin
            r_state <= S_IDLE;
            r_glyph <= '0;
            r_gap   <= '0;
            r_bits  <= 3'b000;
            r_start <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_glyph <= w_glyph_nxt;
            r_gap   <= w_gap_nxt;
            r_bits  <= w_bits_nxt;
            r_start <= (w_state_nxt == S_ROW0);
        end
    end

    // NOTE: every signal gets a default before the case so no path can leave
    // one unassigned and infer a latch; bits defaults to the blank row.
    always_comb begin
        w_state_nxt = r_state;
        w_glyph_nxt = r_glyph;
        w_gap_nxt   = r_gap;
        w_bits_nxt  = 3'b000;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_glyph_nxt = w_head;
                    w_bits_nxt  = w_head[8:6];
                    w_state_nxt = S_ROW0;
                end
            end
            S_ROW0: begin
                w_bits_nxt  = r_glyph[5:3];
                w_state_nxt = S_ROW1;
            end
            S_ROW1: begin
                w_bits_nxt  = r_glyph[2:0];
                w_state_nxt = S_ROW2;
            end
            S_ROW2: begin
                w_gap_nxt   = GW'(1);
                w_state_nxt = S_SEP;
            end
            S_SEP: begin
                if (r_gap < GW'(GAP)) begin
                    w_gap_nxt = r_gap + GW'(1);
                end else if (!w_empty) begin
                    // Last blank row: the next glyph follows without an idle row
                    w_pop       = 1'b1;
                    w_glyph_nxt = w_head;
                    w_bits_nxt  = w_head[8:6];
                    w_state_nxt = S_ROW0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/glyph_streamer.md
# glyph_streamer

Upstream feeder for the letter reader: accepts 3x3 glyphs (9 bits) over a valid/ready handshake, buffers them in a small FIFO, and plays each one out as three registered 3-bit rows (top, middle, bottom) followed by blank 000 separator rows. Its `bits` output drives the reader's `bits` input directly. The reader samples every clock and has no valid signal, so idle time is always shown as 000.

## Interface

Parameters:
- DEPTH, 4: FIFO capacity in glyphs; power of two, >= 2.
- GAP, 1: number of 000 rows emitted after each glyph; >= 1.

Ports:
- clk  in  1  rising-edge clock.
- restart  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer presents a glyph.
- in_glyph  in  9  glyph; [8:6] top row, [5:3] middle row, [2:0] bottom row.
- in_ready  out  1  FIFO can accept; a push happens on an edge where in_valid && in_ready.
- bits  out  3  registered row stream to the reader.
- glyph_start  out  1  high exactly while bits shows a glyph's top row.
- busy  out  1  high when the FIFO is non-empty or the FSM is not in IDLE.
- count  out  $clog2(DEPTH)+1  glyphs currently held in the FIFO.

## Operation

- FIFO:
  - Circular buffer; read and write pointers wrap modulo DEPTH.
  - in_ready = (count != DEPTH), combinational from count only.
  - When the FIFO is full, a push is refused even in a cycle where a pop happens.
- Push and pop on the same edge: count is unchanged, and both pointers advance.
- FSM states: IDLE, ROW0, ROW1, ROW2, SEP.
  - IDLE: bits <= 000. If count != 0, pop the head into the glyph register, bits <= glyph[8:6], go to ROW0.
  - ROW0: bits <= glyph[5:3], go to ROW1.
  - ROW1: bits <= glyph[2:0], go to ROW2.
  - ROW2: bits <= 000, gap counter <= 1, go to SEP.
  - SEP, gap counter < GAP: bits <= 000, gap counter increments, stay in SEP.
  - SEP, gap counter == GAP, FIFO non-empty: pop, bits <= top row, go to ROW0.
  - SEP, gap counter == GAP, FIFO empty: bits <= 000, go to IDLE.
- Pops come only from IDLE or from the last SEP cycle, so there is at most one pop per 3+GAP cycles.
- glyph_start is registered and high exactly while the FSM is in ROW0.
- A glyph pushed on the edge the FSM samples count sees the old count. It is popped no earlier than the next edge.
- Reset, asserted at any time including mid-glyph or mid-push:
  - Asynchronously: bits=000, glyph_start=0, count=0, in_ready=1, busy=0; FSM to IDLE; pointers and gap counter cleared.
  - Buffered and in-flight glyphs are discarded. No partial row is emitted after reset is released.

## Timing

- Empty FIFO, glyph pushed at edge N:
  - Top row visible after edge N+1, middle after N+2, bottom after N+3.
  - 000 after edges N+4 through N+3+GAP.
- Back-to-back glyphs: the next top row appears after edge N+4+GAP. Period is 3+GAP cycles, with exactly GAP 000 rows between glyphs.
- in_ready tracks count with zero latency; count updates on every push or pop edge.
- bits changes only on rising clk edges (or on reset), so it is stable across the reader's sampling edge.

## Test plan

- Reset behaviour:
  - Hold restart=1 for 12 time units: bits=000, glyph_start=0, busy=0, count=0, in_ready=1 throughout.
  - Asserting restart between clock edges clears outputs immediately, without waiting for an edge.
- Single L glyph, GAP=1: push 9'b100_100_111 at edge N.
  - bits = 100, 100, 111, 000 after edges N+1..N+4.
  - glyph_start high only in the cycle after N+1.
  - busy falls after edge N+5; bits holds 000.
- Back-to-back, GAP=1: push 9'b100_100_111 and 9'b111_001_001 on consecutive edges.
  - Stream is 100, 100, 111, 000, 111, 001, 001, 000, with no extra idle row.
- Full FIFO, DEPTH=4, GAP=1: in_valid held high with distinct glyphs from edge 1.
  - count reaches 4 and in_ready drops after edge 5.
  - At edge 6 the pop happens but the offered glyph is not taken.
  - in_ready returns after edge 6 with count=3.
  - Playback order matches push order, with the pointer wrap exercised.
- GAP=3: push two glyphs at once; exactly three 000 rows separate the bottom row of the first from the top row of the second.
- Reset mid-glyph: push 9'b100_100_111, assert restart in the ROW1 cycle, release.
  - bits=000 immediately and stays 000, count=0.
  - Pushing a fresh glyph afterwards plays it from its top row.
